// File: rtl/io_reg_pkg.sv
// Shared types for the I/O register write arbiter: FSM states and grant encoding.
package io_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } gnt_e;

endpackage

// File: rtl/io_reg_write_arbiter_if.sv
// Requester strobes/payloads and the serialised register-bank write port.
interface io_reg_write_arbiter_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8
);
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_data;
    logic          m1_wr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_data;
    logic          clr_req;
    logic          m0_busy;
    logic          m1_busy;
    logic          m0_drop;
    logic          m1_drop;
    logic          reg_we;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_data;
    logic          clr_busy;

    modport master (
        output m0_wr, m0_addr, m0_data, m1_wr, m1_addr, m1_data, clr_req,
        input  m0_busy, m1_busy, m0_drop, m1_drop, reg_we, reg_addr, reg_data, clr_busy
    );

    modport slave (
        input  m0_wr, m0_addr, m0_data, m1_wr, m1_addr, m1_data, clr_req,
        output m0_busy, m1_busy, m0_drop, m1_drop, reg_we, reg_addr, reg_data, clr_busy
    );
endinterface

// File: rtl/io_reg_req_capture.sv
// One requester: strobe rising-edge detect, address range check and a 1-deep write slot.
module io_reg_req_capture
    import io_reg_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned DW   = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          rel,
    output logic          busy,
    output logic          drop,
    output logic [AW-1:0] slot_addr,
    output logic [DW-1:0] slot_data
);

    logic          wr_dly_q, wr_dly_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          rise;
    logic          in_range;
    logic          accept;

    // A slot that is releasing this cycle still counts as full for a new edge.
    always_comb begin
        wr_dly_d = wr;
        full_d   = full_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rise     = wr & ~wr_dly_q;
        in_range = 32'(addr) < NREG;
        accept   = rise & ~full_q & in_range;
        drop_d   = rise & ~accept;
        if (accept) begin
            full_d = 1'b1;
            addr_d = addr;
            data_d = data;
        end else if (rel) begin
            full_d = 1'b0;
        end
    end

    // History flop tracks the strobe even in reset so a held strobe is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_dly_q <= wr;
            full_q   <= 1'b0;
            drop_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_dly_q <= wr_dly_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign busy      = full_q;
    assign drop      = drop_q;
    assign slot_addr = addr_q;
    assign slot_data = data_q;

endmodule

// File: rtl/io_reg_write_arbiter.sv
// Round-robin serialiser of two requesters' register writes onto one bank write port,
// plus a bank-wide clear sequencer.
module io_reg_write_arbiter
    import io_reg_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned DW   = 8
) (
    input logic                  clock,
    input logic                  reset,
    io_reg_write_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    gnt_e          gnt_q, gnt_d;
    gnt_e          ptr_q, ptr_d;
    logic          clr_pend_q, clr_pend_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          reg_we_q, reg_we_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [DW-1:0] reg_data_q, reg_data_d;
    logic          clr_busy_q, clr_busy_d;

    logic          busy0, busy1;
    logic          rel0, rel1;
    logic [AW-1:0] slot0_addr, slot1_addr;
    logic [DW-1:0] slot0_data, slot1_data;

    io_reg_req_capture #(.NREG(NREG), .AW(AW), .DW(DW)) u_cap0 (
        .clock     (clock),
        .reset     (reset),
        .wr        (bus.m0_wr),
        .addr      (bus.m0_addr),
        .data      (bus.m0_data),
        .rel       (rel0),
        .busy      (busy0),
        .drop      (bus.m0_drop),
        .slot_addr (slot0_addr),
        .slot_data (slot0_data)
    );

    io_reg_req_capture #(.NREG(NREG), .AW(AW), .DW(DW)) u_cap1 (
        .clock     (clock),
        .reset     (reset),
        .wr        (bus.m1_wr),
        .addr      (bus.m1_addr),
        .data      (bus.m1_data),
        .rel       (rel1),
        .busy      (busy1),
        .drop      (bus.m1_drop),
        .slot_addr (slot1_addr),
        .slot_data (slot1_data)
    );

    // Bank port outputs are computed with the transition so they are valid in the target state.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        clr_pend_d = clr_pend_q | bus.clr_req;
        clr_cnt_d  = clr_cnt_q;
        reg_we_d   = 1'b0;
        reg_addr_d = '0;
        reg_data_d = '0;
        clr_busy_d = 1'b0;
        rel0       = 1'b0;
        rel1       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d    = CLEAR;
                    clr_pend_d = bus.clr_req;
                    clr_cnt_d  = '0;
                    reg_we_d   = 1'b1;
                    clr_busy_d = 1'b1;
                end else if (busy0 | busy1) begin
                    state_d  = WRITE;
                    reg_we_d = 1'b1;
                    if (busy0 & busy1) gnt_d = ptr_q;
                    else               gnt_d = busy1 ? GNT_M1 : GNT_M0;
                    reg_addr_d = (gnt_d == GNT_M1) ? slot1_addr : slot0_addr;
                    reg_data_d = (gnt_d == GNT_M1) ? slot1_data : slot0_data;
                end
            end
            WRITE: begin
                state_d = IDLE;
                rel0    = (gnt_q == GNT_M0);
                rel1    = (gnt_q == GNT_M1);
                ptr_d   = (gnt_q == GNT_M0) ? GNT_M1 : GNT_M0;
            end
            CLEAR: begin
                if (clr_cnt_q == AW'(NREG - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d  = AW'(clr_cnt_q + 1'b1);
                    reg_we_d   = 1'b1;
                    reg_addr_d = AW'(clr_cnt_q + 1'b1);
                    clr_busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_M0;
            ptr_q      <= GNT_M0;
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            clr_pend_q <= clr_pend_d;
            clr_cnt_q  <= clr_cnt_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign bus.m0_busy  = busy0;
    assign bus.m1_busy  = busy1;
    assign bus.reg_we   = reg_we_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.reg_data = reg_data_q;
    assign bus.clr_busy = clr_busy_q;

endmodule

// File: tb/tb_io_reg_write_arbiter.sv
// Directed bench for io_reg_write_arbiter with a 6-register bank.
module tb_io_reg_write_arbiter;

    localparam int unsigned NREG = 6;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [DW-1:0] bank [0:7];

    io_reg_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    io_reg_write_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Register bank fed by the arbiter's write port.
    always @(posedge clock) begin
        if (bus.reg_we) bank[bus.reg_addr] <= bus.reg_data;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        chk({tag, "_we"}, 32'(bus.reg_we), 32'(we));
        if (we) begin
            chk({tag, "_addr"}, 32'(bus.reg_addr), 32'(a));
            chk({tag, "_data"}, 32'(bus.reg_data), 32'(d));
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bank[i] = 8'hEE;
        reset = 1'b1;
        bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_data = '0;
        bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_data = '0;
        bus.clr_req = 1'b0;
        step(); step(); step();
        chk("rst_we", 32'(bus.reg_we), 0);
        chk("rst_busy", 32'({bus.m0_busy, bus.m1_busy, bus.clr_busy}), 0);
        chk("rst_drop", 32'({bus.m0_drop, bus.m1_drop}), 0);
        reset = 1'b0;
        step();

        // Single write: edge in cycle A, reg_we in A+2.
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd3; bus.m0_data = 8'h5A;
        step();
        chk("sw_busy1", 32'(bus.m0_busy), 1);
        chk_wr("sw_c1", 1'b0, '0, '0);
        bus.m0_wr = 1'b0;
        step();
        chk("sw_busy2", 32'(bus.m0_busy), 1);
        chk_wr("sw_c2", 1'b1, 3'd3, 8'h5A);
        step();
        chk("sw_busy3", 32'(bus.m0_busy), 0);
        chk_wr("sw_c3", 1'b0, '0, '0);

        // Lone m1 write flips the pointer back to requester 0.
        bus.m1_wr = 1'b1; bus.m1_addr = 3'd4; bus.m1_data = 8'h33;
        step();
        bus.m1_wr = 1'b0;
        step();
        chk_wr("m1_c2", 1'b1, 3'd4, 8'h33);
        step();

        // Simultaneous edges, same address; pointer = 0.
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd1; bus.m0_data = 8'h11;
        bus.m1_wr = 1'b1; bus.m1_addr = 3'd1; bus.m1_data = 8'h22;
        step();
        chk("sim_busy", 32'({bus.m0_busy, bus.m1_busy}), 32'b11);
        bus.m0_wr = 1'b0; bus.m1_wr = 1'b0;
        step();
        chk_wr("sim_first", 1'b1, 3'd1, 8'h11);
        step();
        chk_wr("sim_gap", 1'b0, '0, '0);
        chk("sim_busy_gap", 32'({bus.m0_busy, bus.m1_busy}), 32'b01);
        step();
        chk_wr("sim_second", 1'b1, 3'd1, 8'h22);
        step();
        chk("sim_bank1", 32'(bank[1]), 32'h22);

        // Second simultaneous pair confirms the pointer returned to 0.
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd5; bus.m0_data = 8'h55;
        bus.m1_wr = 1'b1; bus.m1_addr = 3'd0; bus.m1_data = 8'h66;
        step();
        bus.m0_wr = 1'b0; bus.m1_wr = 1'b0;
        step();
        chk_wr("ptr_first", 1'b1, 3'd5, 8'h55);
        step(); step();
        chk_wr("ptr_second", 1'b1, 3'd0, 8'h66);
        step();

        // Overrun: second m1 edge lands while the slot is still full.
        bus.m1_wr = 1'b1; bus.m1_addr = 3'd2; bus.m1_data = 8'hA1;
        step();
        bus.m1_wr = 1'b0;
        step();
        chk_wr("ovr_first", 1'b1, 3'd2, 8'hA1);
        bus.m1_wr = 1'b1; bus.m1_addr = 3'd2; bus.m1_data = 8'hB2;
        step();
        bus.m1_wr = 1'b0;
        chk("ovr_drop", 32'(bus.m1_drop), 1);
        chk("ovr_busy", 32'(bus.m1_busy), 0);
        chk_wr("ovr_c3", 1'b0, '0, '0);
        step();
        chk("ovr_drop_end", 32'(bus.m1_drop), 0);
        chk_wr("ovr_c4", 1'b0, '0, '0);
        step();
        chk_wr("ovr_c5", 1'b0, '0, '0);
        chk("ovr_bank2", 32'(bank[2]), 32'hA1);

        // Out-of-range addresses 7 and 6 are dropped.
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd7; bus.m0_data = 8'h77;
        step();
        bus.m0_wr = 1'b0;
        chk("oor7_drop", 32'(bus.m0_drop), 1);
        chk("oor7_busy", 32'(bus.m0_busy), 0);
        step();
        chk("oor7_drop_end", 32'(bus.m0_drop), 0);
        chk_wr("oor7_c2", 1'b0, '0, '0);
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd6; bus.m0_data = 8'h76;
        step();
        bus.m0_wr = 1'b0;
        chk("oor6_drop", 32'(bus.m0_drop), 1);
        step();
        chk_wr("oor6_c2", 1'b0, '0, '0);
        step();

        // Clear with an m0 write captured during CLEAR.
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        chk("clr_idle_busy", 32'(bus.clr_busy), 0);
        chk_wr("clr_idle", 1'b0, '0, '0);
        step();
        for (int i = 0; i < int'(NREG); i++) begin
            chk("clr_busy", 32'(bus.clr_busy), 1);
            chk_wr("clr_zero", 1'b1, AW'(i), 8'h00);
            if (i == 0) begin
                bus.m0_wr = 1'b1; bus.m0_addr = 3'd2; bus.m0_data = 8'hFF;
            end else if (i == 1) begin
                bus.m0_wr = 1'b0;
                chk("clr_slot_busy", 32'(bus.m0_busy), 1);
            end
            step();
        end
        chk("clr_done_busy", 32'(bus.clr_busy), 0);
        chk_wr("clr_done", 1'b0, '0, '0);
        step();
        chk_wr("clr_held_write", 1'b1, 3'd2, 8'hFF);
        step();
        chk("clr_bank2", 32'(bank[2]), 32'hFF);
        chk("clr_bank1", 32'(bank[1]), 32'h00);
        chk("clr_bank4", 32'(bank[4]), 32'h00);

        // Strobe held high through reset release is not an edge.
        reset = 1'b1;
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd3; bus.m0_data = 8'h99;
        step(); step();
        reset = 1'b0;
        step();
        chk("hold_busy", 32'(bus.m0_busy), 0);
        step();
        chk_wr("hold_c2", 1'b0, '0, '0);
        step();
        chk_wr("hold_c3", 1'b0, '0, '0);
        bus.m0_wr = 1'b0;
        step();

        // Reset mid-CLEAR loses both the clear and a captured write.
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        step();
        chk_wr("rc_clr0", 1'b1, 3'd0, 8'h00);
        bus.m0_wr = 1'b1; bus.m0_addr = 3'd5; bus.m0_data = 8'h05;
        step();
        bus.m0_wr = 1'b0;
        chk("rc_slot_busy", 32'(bus.m0_busy), 1);
        reset = 1'b1;
        step();
        chk_wr("rc_after_rst", 1'b0, '0, '0);
        chk("rc_clr_busy", 32'(bus.clr_busy), 0);
        chk("rc_slot_empty", 32'(bus.m0_busy), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_wr("rc_quiet", 1'b0, '0, '0);
        end
        chk("rc_bank5", 32'(bank[5]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
